// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between MEM/WB writeback and queued MDU results.
// Define RF_WR_FAIR_EN to add a starvation timer that forces a queued drain over the pipeline.
module rf_wr_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DW-1:0]          wb_data,
  output logic                   wb_stall,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [AW-1:0]          mdu_addr,
  input  logic [DW-1:0]          mdu_data,
  input  logic [AW-1:0]          rd_a1,
  input  logic [AW-1:0]          rd_a2,
  output logic                   hz1,
  output logic                   hz2,
  output logic                   rf_wr,
  output logic [AW-1:0]          rf_a3,
  output logic [DW-1:0]          rf_wd,
  output logic [$clog2(DEPTH):0] pend_cnt
);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_wr_arbiter: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("rf_wr_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic          live_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic full;
  logic empty;
  logic head_live;
  logic head_ok;
  logic wb_req;
  logic wb_commit;
  logic force_drain;
  logic push;
  logic pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_live = live_q[head];
  assign head_ok   = !empty && head_live;
  assign wb_req    = wb_valid && (wb_addr != '0);
  assign wb_commit = wb_req && !force_drain;
  // A dead head is dropped regardless of who owns the port.
  assign pop       = !empty && (!head_live || force_drain || !wb_req);
  assign mdu_ready = !full && !rst;
  assign push      = mdu_valid && mdu_ready;
  assign pend_cnt  = count;
  assign wb_stall  = force_drain && !rst;

`ifdef RF_WR_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_left;

  assign force_drain = head_ok && (starve_left == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_left <= SW'(STARVE_LIMIT);
    end else if (pop) begin
      starve_left <= SW'(STARVE_LIMIT);
    end else if (head_ok && wb_commit && starve_left != '0) begin
      starve_left <= starve_left - 1'b1;
    end
  end
`else
  assign force_drain = 1'b0;
`endif

  always_comb begin
    rf_wr = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (!rst) begin
      if (force_drain || (head_ok && !wb_req)) begin
        rf_wr = 1'b1;
        rf_a3 = addr_q[head];
        rf_wd = data_q[head];
      end else if (wb_req) begin
        rf_wr = 1'b1;
        rf_a3 = wb_addr;
        rf_wd = wb_data;
      end
    end
  end

  // Live bits exist only on occupied entries, so no occupancy mask is needed here.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == rd_a1) && (rd_a1 != '0)) hz1 = 1'b1;
      if (live_q[i] && (addr_q[i] == rd_a2) && (rd_a2 != '0)) hz2 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
    end else begin
      // A committed pipeline write is younger than anything already queued for that register.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_commit && live_q[i] && (addr_q[i] == wb_addr)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        live_q[tail] <= (mdu_addr != '0);
        tail         <= tail + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= mdu_addr;
      data_q[tail] <= mdu_data;
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: vector table, directed corner sequences and a
// randomized run compared against a queue-based reference model of the arbitration rules.
module tb_rf_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef RF_WR_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic [AW-1:0] rd_a1;
  logic [AW-1:0] rd_a2;
  logic          hz1;
  logic          hz2;
  logic          rf_wr;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd;
  logic [1:0]    pend_cnt;

  rf_wr_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .hz1(hz1), .hz2(hz2),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          wbv;
    logic [AW-1:0] wba;
    logic [DW-1:0] wbd;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          e_wr;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    logic          e_rdy;
    logic          e_hz1;
    logic          e_hz2;
    logic [1:0]    e_pend;
  } vec_t;

  ent_t          q[$];
  int            age;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] dut_rf [32];
  logic [AW-1:0] wr_log[$];
  bit            last_ready;
  bit            last_stall;
  bit            saw_stale;
  int            checks;
  int            errors;
  int            sent;
  vec_t          tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Check outputs at the negedge against the model, then step the model across the coming posedge.
  task automatic sample();
    bit hl, frc, wreq, pop, ew, e1, e2;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    hl   = (q.size() > 0) && q[0].live;
    frc  = FAIR && hl && (age >= STARVE_LIMIT);
    wreq = wb_valid && (wb_addr != 0);
    ew = 1'b0; ea = '0; ed = '0;
    if (frc || (hl && !wreq)) begin
      ew = 1'b1; ea = q[0].addr; ed = q[0].data;
    end else if (wreq) begin
      ew = 1'b1; ea = wb_addr; ed = wb_data;
    end
    e1 = 1'b0; e2 = 1'b0;
    foreach (q[i]) begin
      if (q[i].live && q[i].addr == rd_a1 && rd_a1 != 0) e1 = 1'b1;
      if (q[i].live && q[i].addr == rd_a2 && rd_a2 != 0) e2 = 1'b1;
    end
    last_ready = (q.size() < DEPTH);
    last_stall = frc;
    chk("rf_wr", rf_wr, ew);
    chk("rf_a3", rf_a3, ea);
    chk("rf_wd", rf_wd, ed);
    chk("wb_stall", wb_stall, frc);
    chk("mdu_ready", mdu_ready, last_ready);
    chk("hz1", hz1, e1);
    chk("hz2", hz2, e2);
    chk("pend_cnt", pend_cnt, q.size());
    if (rf_wr === 1'b1) begin
      dut_rf[rf_a3] = rf_wd;
      if (rf_a3 >= 10 && rf_a3 <= 12) wr_log.push_back(rf_a3);
      if (rf_a3 == 9 && rf_wd == 32'h11) saw_stale = 1'b1;
    end
    if (ew) model_rf[ea] = ed;
    pop = (q.size() > 0) && (!q[0].live || frc || (hl && !wreq));
    if (pop) age = 0;
    else if (hl && wreq && !frc) age++;
    if (pop) void'(q.pop_front());
    if (wreq && !frc) begin
      foreach (q[i]) if (q[i].addr == wb_addr) q[i].live = 1'b0;
    end
    if (mdu_valid && last_ready) q.push_back('{live: (mdu_addr != 0), addr: mdu_addr, data: mdu_data});
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    rd_a1 = '0; rd_a2 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    q.delete();
    age = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; saw_stale = 1'b0;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i] = '0;
    end

    tbl[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd5, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'h44,   5'd4, 5'd0, 1'b1, 5'd3, 32'hAA,   1'b1, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 5'd3, 32'hAB, 1'b0, 5'd0, 32'h0,    5'd4, 5'd0, 1'b1, 5'd3, 32'hAB,   1'b1, 1'b1, 1'b0, 2'd1};
    tbl[5] = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77,   5'd4, 5'd0, 1'b1, 5'd4, 32'h44,   1'b1, 1'b1, 1'b0, 2'd1};
    tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 2'd0};

    rst = 1'b1;
    idle_inputs();
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    #3;
    chk("rst_rf_wr", rf_wr, 1'b0);
    chk("rst_mdu_ready", mdu_ready, 1'b0);
    chk("rst_pend", pend_cnt, 2'd0);
    do_reset();

    // Vector table: idle drain, hazards, r0 pipeline write frees the port, dead r0 entry dropped.
    for (int r = 0; r < 8; r++) begin
      wb_valid = tbl[r].wbv; wb_addr = tbl[r].wba; wb_data = tbl[r].wbd;
      mdu_valid = tbl[r].mv; mdu_addr = tbl[r].ma; mdu_data = tbl[r].md;
      rd_a1 = tbl[r].ra1; rd_a2 = tbl[r].ra2;
      sample();
      chk($sformatf("tbl%0d_rf_wr", r), rf_wr, tbl[r].e_wr);
      chk($sformatf("tbl%0d_rf_a3", r), rf_a3, tbl[r].e_a3);
      chk($sformatf("tbl%0d_rf_wd", r), rf_wd, tbl[r].e_wd);
      chk($sformatf("tbl%0d_ready", r), mdu_ready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_hz1", r), hz1, tbl[r].e_hz1);
      chk($sformatf("tbl%0d_hz2", r), hz2, tbl[r].e_hz2);
      chk($sformatf("tbl%0d_pend", r), pend_cnt, tbl[r].e_pend);
      advance();
    end

    // Contention: r7 queued while the pipeline writes r3 for six cycles.
    do_reset();
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hBB;
    sample(); advance();
    mdu_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    for (int c = 1; c <= 6; c++) begin
      sample();
`ifdef RF_WR_FAIR_EN
      if (c == 5) begin
        chk("cont_force_a3", rf_a3, 5'd7);
        chk("cont_force_stall", wb_stall, 1'b1);
      end else begin
        chk("cont_wb_a3", rf_a3, 5'd3);
        chk("cont_wb_stall", wb_stall, 1'b0);
      end
`else
      chk("cont_wb_a3", rf_a3, 5'd3);
      chk("cont_wb_stall", wb_stall, 1'b0);
`endif
      advance();
    end
    wb_valid = 1'b0;
    sample();
`ifdef RF_WR_FAIR_EN
    chk("cont_after_rf_wr", rf_wr, 1'b0);
`else
    chk("cont_after_a3", rf_a3, 5'd7);
    chk("cont_after_wd", rf_wd, 32'hBB);
`endif
    advance();

    // Backpressure: three back-to-back MDU results against a busy port.
    do_reset();
    wr_log.delete();
    sent = 0;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hCC;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) wb_valid = 1'b0;
      mdu_valid = (sent < 3);
      mdu_addr = 5'(10 + sent);
      mdu_data = 32'(sent + 32'hC0);
      sample();
      if (c == 2) chk("bp_third_blocked", mdu_ready, 1'b0);
      if (mdu_valid && last_ready) sent++;
      advance();
    end
    chk("bp_all_sent", sent, 3);
    chk("bp_write_count", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) chk("bp_order", wr_log[i], 5'(10 + i));

    // Kill: queued r9 superseded by a younger pipeline write.
    do_reset();
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h2;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h11;
    sample(); advance();
    mdu_valid = 1'b0; wb_addr = 5'd9; wb_data = 32'h22;
    sample(); advance();
    wb_valid = 1'b0; rd_a1 = 5'd9;
    sample();
    chk("kill_no_wr", rf_wr, 1'b0);
    chk("kill_no_hz", hz1, 1'b0);
    chk("kill_pend_dead", pend_cnt, 2'd1);
    advance();
    sample(); advance();
    chk("kill_final_r9", dut_rf[9], 32'h22);
    chk("kill_no_stale", saw_stale, 1'b0);

    // Reset mid-operation with two queued entries.
    do_reset();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h20;
    sample(); advance();
    mdu_addr = 5'd21; mdu_data = 32'h21;
    sample(); advance();
    mdu_valid = 1'b0; rd_a1 = 5'd20;
    sample();
    chk("prerst_pend", pend_cnt, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pend", pend_cnt, 2'd0);
    chk("midrst_rf_wr", rf_wr, 1'b0);
    chk("midrst_ready", mdu_ready, 1'b0);
    chk("midrst_hz1", hz1, 1'b0);
    chk("midrst_stall", wb_stall, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    wb_valid = 1'b0;
    q.delete();
    age = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("postrst_ready", mdu_ready, 1'b1);
      chk("postrst_rf_wr", rf_wr, 1'b0);
      advance();
    end

    // Randomized traffic against the model; stalled or refused requests are held unchanged.
    do_reset();
    begin
      bit hold_w, hold_m;
      hold_w = 1'b0; hold_m = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if (!hold_w) begin
          wb_valid = ($urandom_range(0, 9) < 6);
          wb_addr = 5'($urandom_range(0, 7));
          wb_data = $urandom;
        end
        if (!hold_m) begin
          mdu_valid = ($urandom_range(0, 2) == 0);
          mdu_addr = 5'($urandom_range(0, 7));
          mdu_data = $urandom;
        end
        rd_a1 = 5'($urandom_range(0, 7));
        rd_a2 = 5'($urandom_range(0, 7));
        sample();
        hold_w = wb_valid && last_stall;
        hold_m = mdu_valid && !last_ready;
        advance();
      end
    end
    idle_inputs();
    repeat (4) begin
      sample(); advance();
    end

    for (int i = 1; i < 32; i++) chk($sformatf("rf_r%0d", i), dut_rf[i], model_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Shares the register file's single write port between the in-order pipeline writeback (MEM/WB) and a multi-cycle unit (MDU: mul/div) that completes out of order. Pipeline writes win by default. MDU results are held in a small pending queue and drained into the register file on idle write-port cycles. The block also reports read-after-write hazards against queued results, so the hazard unit can stall readers, and drops queued results made stale by a younger pipeline write.

## Interface
Parameters:
- DW, 32, data width
- AW, 5, register address width
- DEPTH, 2, pending-queue entries (power of two, ≥2)
- STARVE_LIMIT, 4, blocked cycles before a forced MDU drain (used only with RF_WR_FAIR_EN)

Ports:
- clk  in  1  clock; the register file samples rf_* on negedge, this block updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  pipeline writeback request
- wb_addr  in  AW  pipeline destination register
- wb_data  in  DW  pipeline result
- wb_stall  out  1  pipeline writeback refused this cycle; hold wb_*
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  queue can accept; transfer occurs when valid&&ready at posedge
- mdu_addr  in  AW  MDU destination register
- mdu_data  in  DW  MDU result
- rd_a1, rd_a2  in  AW  decode-stage source registers
- hz1, hz2  out  1  source matches a live queued entry
- rf_wr, rf_a3, rf_wd  out  1/AW/DW  register-file write port (RFWr/A3/WD)
- pend_cnt  out  log2(DEPTH)+1  occupied queue entries

## Operation
- Queue entry: {live, addr, data}. Circular buffer with head/tail pointers and a count.
- Push: mdu_valid && mdu_ready. The entry is written live=1, or live=0 if mdu_addr==0.
- mdu_ready = !full && !rst. It is registered-state only and has no combinational dependence on the pop in the same cycle.
- Write-port select, evaluated each cycle in this priority order:
  - force (fair mode only): rf_* ← head; wb_stall=1; pop.
  - wb_valid && wb_addr!=0: rf_wr=1, rf_a3=wb_addr, rf_wd=wb_data.
  - Queue non-empty and head live: rf_* ← head; pop.
  - Otherwise: rf_wr=0, rf_a3=0, rf_wd=0.
- Dead head (live=0) is popped silently in any cycle, including one in which the pipeline writes. rf_wr is not asserted for it.
- wb_valid with wb_addr==0: no rf_wr. The port is treated as free, so the queue head may drain.
- Kill rule: when a pipeline write with wb_addr!=0 commits, every live entry with addr==wb_addr is cleared to live=0 at that posedge. Rationale: the pipeline write is younger in program order.
- Hazards: hzN = (rd_aN!=0) && any live entry matches rd_aN. The check is combinational. Entries being pushed in the same cycle are excluded.
- Pop and push in the same cycle are legal; count is unchanged.

## Timing
- Reset (async): head=tail=count=0, all live=0, starve counter=0. Outputs: rf_wr=0, rf_a3=0, rf_wd=0, wb_stall=0, mdu_ready=0 while rst is high and 1 after it, hz1=hz2=0, pend_cnt=0.
- rst asserted mid-operation discards queued results. No partial write is issued.
- MDU latency: accepted at posedge k; earliest rf_wr is in cycle k+1 (written at the negedge inside k+1); popped at posedge k+2.
- Pipeline write: zero added latency; rf_* is combinational from wb_*.
- Full queue: mdu_ready=0. The MDU must hold its result; nothing is dropped.

## Configuration
- RF_WR_FAIR_EN defined:
  - An age counter increments each cycle the queue holds a live head and the port goes to the pipeline.
  - The counter clears on every pop.
  - When the count reaches STARVE_LIMIT, force=1 for one cycle: the head is written and wb_stall=1.
- RF_WR_FAIR_EN undefined: no counter, force=0, wb_stall tied 0. The pipeline always wins, and the queue drains only on idle cycles.

## Test plan
- Idle port: MDU pushes r5=0x1234 at k → rf_wr=1, rf_a3=5, rf_wd=0x1234 in k+1; pend_cnt 1→0 at k+2.
- Contention: wb_valid held with r3=0xAA for 6 cycles while r7=0xBB is queued → without the macro, r7 is written in the first cycle after wb_valid drops. With the macro, r7 is written and wb_stall=1 in the 5th cycle (STARVE_LIMIT=4).
- Backpressure: 3 back-to-back MDU results with wb_valid high → first two accepted; mdu_ready=0 on the third until a pop. No loss, in-order writes.
- Kill: queue holds r9=0x11, then pipeline writes r9=0x22 → entry popped silently with no rf_wr for r9. Final value r9=0x22.
- Hazard/r0: queue r4, rd_a1=4 → hz1=1. rd_a2=0 → hz2=0. MDU push to r0 → never asserts rf_wr.
- Reset: assert rst with 2 queued entries → pend_cnt=0, no rf_wr after release, mdu_ready=1 one cycle later.
